decode_execute_reg: RTL and testbench
=====================================

# decode_execute_reg

Decode→Execute pipeline register for the pipelined ARM core. It captures decoded control fields, register-file read data, the extended immediate and register addresses at the end of Decode. It presents them to the Execute stage: conditional logic, ALU, forwarding muxes and hazard unit. It supports a stall (hold) from the hazard unit and a flush (bubble insertion) for branch and load-use recovery, and tracks a valid bit per slot.

## Interface
Parameters:
- DATA_W, 32, datapath width of RD1/RD2/ExtImm
- ADDR_W, 4, register-address width (RA1/RA2/WA3)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears every register immediately
- StallE  in  1  hold current contents (hazard unit)
- FlushE  in  1  load a bubble on next edge (hazard unit); priority over StallE
- ValidD  in  1  Decode slot holds a real instruction
- CondD  in  4  condition field
- FlagWriteD  in  2  flag-group write enables {NZ, CV}
- PCSrcD, RegWriteD, MemWriteD, BranchD, MemtoRegD, ALUSrcD, NoWriteD  in  1 each  decoded control
- ALUControlD  in  2  ALU operation
- RD1D, RD2D, ExtImmD  in  DATA_W each  operands
- RA1D, RA2D, WA3D  in  ADDR_W each  source/destination register numbers
- ValidE  out  1  Execute slot holds a real instruction
- CondE … WA3E  out  same widths  registered copies of every D input above, one-to-one

## Operation
- Per rising edge, exactly one action, highest priority first:
  1. **reset** (async): all outputs 0.
  2. **FlushE=1**: bubble. ValidE=0 and every control output (FlagWriteE, PCSrcE, RegWriteE, MemWriteE, BranchE, MemtoRegE, ALUSrcE, NoWriteE, ALUControlE) is 0. CondE=0, all datapath and address outputs=0.
  3. **StallE=1**: all outputs hold.
  4. **Otherwise**: load all D inputs, ValidE←ValidD.
- A bubble must be architecturally invisible downstream. With all enables 0, conditional logic writes no register, memory, flags or PC, whatever CondE evaluates to.
- ValidD=0 with no flush/stall: fields are loaded as presented. Decode guarantees its controls are already 0 in that case; this block does not mask them.
- No combinational path from any input to any output; outputs are pure flop Q.
- Widths pass unchanged: no sign extension or truncation inside this block.

## Timing
- Latency 1 cycle: values on D inputs at edge n appear on E outputs after edge n, stable for all of cycle n+1.
- StallE and FlushE both high: flush wins (bubble loaded).
- Stall held k cycles: outputs unchanged for k edges, then the pending D values load on the first edge with StallE=0.
- Flush for one cycle followed by normal operation: exactly one bubble cycle (ValidE=0), then the D values from the following edge appear.
- Reset asserted mid-stream: outputs go to 0 without waiting for clk. The first load occurs on the first rising edge after reset deasserts.
- All outputs reset to 0, including ValidE=0 and CondE=4'b0000.

## Structure
- Shared package pipeline_pkg:
  - struct de_ctrl_t bundling all 1-bit controls, ALUControl[1:0], FlagWrite[1:0] and Cond[3:0].
  - constant DE_CTRL_BUBBLE (all zero).
  - localparams DATA_W=32, ADDR_W=4.
- Ports stay flat (per-signal) for compatibility with the existing stage modules. Internally, packing into de_ctrl_t is allowed.
- One generic sub-module, flopenrc: parameterised width, async reset, active-high enable, synchronous clear.
  - Instantiate once for control+valid and once for datapath+addresses.
  - enable = ~StallE | FlushE, clear = FlushE.

## Test plan
- Reset: drive all D inputs to 1s, assert reset between edges → all E outputs 0 immediately, ValidE=0. Outputs remain 0 until the first edge after release.
- Pass-through: ValidD=1, CondD=4'hE, RegWriteD=1, RD1D=32'h0000_1234, WA3D=4'd5 → after one edge ValidE=1, CondE=4'hE, RegWriteE=1, RD1E=32'h0000_1234, WA3E=5.
- Stall: load RD2D=32'hAAAA_AAAA; next two cycles StallE=1 with RD2D=32'h5555_5555 → RD2E stays 32'hAAAA_AAAA for two cycles. It becomes 32'h5555_5555 on the first edge with StallE=0.
- Flush: pipeline holding MemWriteE=1, BranchE=1; assert FlushE one cycle → next cycle ValidE=0, MemWriteE=0, BranchE=0, RD1E=0.
- Flush+stall together: StallE=1, FlushE=1 → bubble loaded (ValidE=0, all controls 0), not a hold.
- Back-to-back: stream 4 instructions with WA3D=1,2,3,4 and no hazards → WA3E shows 1,2,3,4 on consecutive cycles with ValidE=1 throughout.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the ARM core stage registers.
package pipeline_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    // Decoded control fields carried from Decode into Execute.
    typedef struct packed {
        logic [3:0] cond;
        logic [1:0] flag_write;   // {NZ, CV}
        logic [1:0] alu_control;
        logic       pc_src;
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       mem_to_reg;
        logic       alu_src;
        logic       no_write;
    } de_ctrl_t;

    localparam int DE_CTRL_W = $bits(de_ctrl_t);

    // A bubble: every write enable and the condition field cleared, so the
    // Execute-stage conditional logic can commit nothing from this slot.
    localparam de_ctrl_t DE_CTRL_BUBBLE = de_ctrl_t'({DE_CTRL_W{1'b0}});

endpackage

// File: rtl/flopenrc.sv
// Generic register: async reset, active-high enable, synchronous clear.
// Clear only acts when the register is enabled.
module flopenrc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    // State register: reset > enabled clear > enabled load > hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= {WIDTH{1'b0}};
        end else if (en_i) begin
            if (clr_i) begin
                q_q <= {WIDTH{1'b0}};
            end else begin
                q_q <= d_i;
            end
        end else begin
            q_q <= q_q;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/decode_execute_reg.sv
// Decode->Execute pipeline register with stall (hold), flush (bubble) and
// a per-slot valid bit. Outputs are driven straight from flop Q.
module decode_execute_reg
    import pipeline_pkg::de_ctrl_t;
    import pipeline_pkg::DE_CTRL_W;
    import pipeline_pkg::DE_CTRL_BUBBLE;
#(
    parameter int DATA_W = pipeline_pkg::DATA_W,
    parameter int ADDR_W = pipeline_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StallE,
    input  logic              FlushE,
    input  logic              ValidD,
    input  logic [3:0]        CondD,
    input  logic [1:0]        FlagWriteD,
    input  logic              PCSrcD,
    input  logic              RegWriteD,
    input  logic              MemWriteD,
    input  logic              BranchD,
    input  logic              MemtoRegD,
    input  logic              ALUSrcD,
    input  logic              NoWriteD,
    input  logic [1:0]        ALUControlD,
    input  logic [DATA_W-1:0] RD1D,
    input  logic [DATA_W-1:0] RD2D,
    input  logic [DATA_W-1:0] ExtImmD,
    input  logic [ADDR_W-1:0] RA1D,
    input  logic [ADDR_W-1:0] RA2D,
    input  logic [ADDR_W-1:0] WA3D,
    output logic              ValidE,
    output logic [3:0]        CondE,
    output logic [1:0]        FlagWriteE,
    output logic              PCSrcE,
    output logic              RegWriteE,
    output logic              MemWriteE,
    output logic              BranchE,
    output logic              MemtoRegE,
    output logic              ALUSrcE,
    output logic              NoWriteE,
    output logic [1:0]        ALUControlE,
    output logic [DATA_W-1:0] RD1E,
    output logic [DATA_W-1:0] RD2E,
    output logic [DATA_W-1:0] ExtImmE,
    output logic [ADDR_W-1:0] RA1E,
    output logic [ADDR_W-1:0] RA2E,
    output logic [ADDR_W-1:0] WA3E
);

    localparam int CTL_W  = DE_CTRL_W + 1;            // valid + controls
    localparam int DATA_BUS_W = 3 * DATA_W + 3 * ADDR_W;

    de_ctrl_t              ctrl_in_s;
    de_ctrl_t              ctrl_d;
    logic                  valid_d;
    de_ctrl_t              ctrl_q;
    logic                  valid_q;
    logic [CTL_W-1:0]      ctl_bus_q;
    logic [DATA_BUS_W-1:0] data_d;
    logic [DATA_BUS_W-1:0] data_q;
    logic                  en_s;

    // Flush must still move the register even while the hazard unit stalls.
    assign en_s = ~StallE | FlushE;

    assign ctrl_in_s = '{cond:        CondD,
                         flag_write:  FlagWriteD,
                         alu_control: ALUControlD,
                         pc_src:      PCSrcD,
                         reg_write:   RegWriteD,
                         mem_write:   MemWriteD,
                         branch:      BranchD,
                         mem_to_reg:  MemtoRegD,
                         alu_src:     ALUSrcD,
                         no_write:    NoWriteD};

    // Next control word: a flush substitutes the bubble pattern explicitly.
    always_comb begin
        ctrl_d  = ctrl_in_s;
        valid_d = ValidD;
        if (FlushE) begin
            ctrl_d  = DE_CTRL_BUBBLE;
            valid_d = 1'b0;
        end else begin
            ctrl_d  = ctrl_in_s;
            valid_d = ValidD;
        end
    end

    assign data_d = {RD1D, RD2D, ExtImmD, RA1D, RA2D, WA3D};

    flopenrc #(.WIDTH(CTL_W)) u_ctrl_reg (
        .clk   (clk),
        .reset (reset),
        .en_i  (en_s),
        .clr_i (FlushE),
        .d_i   ({valid_d, ctrl_d}),
        .q_o   (ctl_bus_q)
    );

    flopenrc #(.WIDTH(DATA_BUS_W)) u_data_reg (
        .clk   (clk),
        .reset (reset),
        .en_i  (en_s),
        .clr_i (FlushE),
        .d_i   (data_d),
        .q_o   (data_q)
    );

    assign valid_q = ctl_bus_q[CTL_W-1];
    assign ctrl_q  = de_ctrl_t'(ctl_bus_q[DE_CTRL_W-1:0]);

    assign ValidE      = valid_q;
    assign CondE       = ctrl_q.cond;
    assign FlagWriteE  = ctrl_q.flag_write;
    assign ALUControlE = ctrl_q.alu_control;
    assign PCSrcE      = ctrl_q.pc_src;
    assign RegWriteE   = ctrl_q.reg_write;
    assign MemWriteE   = ctrl_q.mem_write;
    assign BranchE     = ctrl_q.branch;
    assign MemtoRegE   = ctrl_q.mem_to_reg;
    assign ALUSrcE     = ctrl_q.alu_src;
    assign NoWriteE    = ctrl_q.no_write;

    assign {RD1E, RD2E, ExtImmE, RA1E, RA2E, WA3E} = data_q;

endmodule

// File: tb/tb_decode_execute_reg.sv
// Directed, table-driven bench for decode_execute_reg.
module tb_decode_execute_reg;

    typedef struct packed {
        logic        valid;
        logic [3:0]  cond;
        logic [1:0]  fw;
        logic [6:0]  ctl;   // {pcsrc, regwrite, memwrite, branch, memtoreg, alusrc, nowrite}
        logic [1:0]  aluc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] ext;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic [3:0]  wa3;
    } fields_t;

    typedef struct {
        logic    stall;
        logic    flush;
        fields_t d;
        fields_t e;
        string   name;
    } vec_t;

    logic    clk;
    logic    reset;
    logic    StallE;
    logic    FlushE;
    fields_t din;
    fields_t got;
    fields_t zero_f;
    fields_t ones_f;

    int nchecks;
    int nerrors;

    logic              ValidE, PCSrcE, RegWriteE, MemWriteE, BranchE, MemtoRegE, ALUSrcE, NoWriteE;
    logic [3:0]        CondE;
    logic [1:0]        FlagWriteE, ALUControlE;
    logic [31:0]       RD1E, RD2E, ExtImmE;
    logic [3:0]        RA1E, RA2E, WA3E;

    decode_execute_reg #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .StallE      (StallE),
        .FlushE      (FlushE),
        .ValidD      (din.valid),
        .CondD       (din.cond),
        .FlagWriteD  (din.fw),
        .PCSrcD      (din.ctl[6]),
        .RegWriteD   (din.ctl[5]),
        .MemWriteD   (din.ctl[4]),
        .BranchD     (din.ctl[3]),
        .MemtoRegD   (din.ctl[2]),
        .ALUSrcD     (din.ctl[1]),
        .NoWriteD    (din.ctl[0]),
        .ALUControlD (din.aluc),
        .RD1D        (din.rd1),
        .RD2D        (din.rd2),
        .ExtImmD     (din.ext),
        .RA1D        (din.ra1),
        .RA2D        (din.ra2),
        .WA3D        (din.wa3),
        .ValidE      (ValidE),
        .CondE       (CondE),
        .FlagWriteE  (FlagWriteE),
        .PCSrcE      (PCSrcE),
        .RegWriteE   (RegWriteE),
        .MemWriteE   (MemWriteE),
        .BranchE     (BranchE),
        .MemtoRegE   (MemtoRegE),
        .ALUSrcE     (ALUSrcE),
        .NoWriteE    (NoWriteE),
        .ALUControlE (ALUControlE),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .ExtImmE     (ExtImmE),
        .RA1E        (RA1E),
        .RA2E        (RA2E),
        .WA3E        (WA3E)
    );

    assign got = {ValidE, CondE, FlagWriteE,
                  {PCSrcE, RegWriteE, MemWriteE, BranchE, MemtoRegE, ALUSrcE, NoWriteE},
                  ALUControlE, RD1E, RD2E, ExtImmE, RA1E, RA2E, WA3E};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic fields_t mk(input logic v, input logic [3:0] c, input logic [1:0] fw,
                                   input logic [6:0] ctl, input logic [1:0] aluc,
                                   input logic [31:0] rd1, input logic [31:0] rd2,
                                   input logic [31:0] ext, input logic [3:0] ra1,
                                   input logic [3:0] ra2, input logic [3:0] wa3);
        mk = {v, c, fw, ctl, aluc, rd1, rd2, ext, ra1, ra2, wa3};
    endfunction

    task automatic check(input string name, input fields_t exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    vec_t vecs[16];
    fields_t fa, fb, fc, fd, fe, ff;

    initial begin
        nchecks = 0;
        nerrors = 0;
        zero_f  = '0;
        ones_f  = '1;

        // A: basic pass-through; B: loaded before stall (memwrite+branch)
        fa = mk(1'b1, 4'hE, 2'b00, 7'b0100000, 2'b00, 32'h0000_1234, 32'h0, 32'h0, 4'd0, 4'd0, 4'd5);
        fb = mk(1'b1, 4'h0, 2'b11, 7'b0011010, 2'b10, 32'hDEAD_BEEF, 32'hAAAA_AAAA, 32'h0000_00FF, 4'd3, 4'd7, 4'd9);
        fc = mk(1'b1, 4'h1, 2'b01, 7'b1000001, 2'b01, 32'h1111_2222, 32'h5555_5555, 32'hFFFF_FF80, 4'd1, 4'd2, 4'd3);
        fd = mk(1'b1, 4'hA, 2'b10, 7'b0110100, 2'b11, 32'hCAFE_F00D, 32'h0BAD_0BAD, 32'h0000_0004, 4'd14, 4'd13, 4'd12);
        fe = mk(1'b1, 4'h8, 2'b00, 7'b0100010, 2'b01, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'd15, 4'd0, 4'd11);
        ff = mk(1'b0, 4'hE, 2'b00, 7'b0000000, 2'b00, 32'h0000_00AB, 32'h0000_00CD, 32'h0000_00EF, 4'd4, 4'd6, 4'd8);

        vecs[0]  = '{1'b0, 1'b0, fa, fa, "pass_through"};
        vecs[1]  = '{1'b0, 1'b0, fb, fb, "load_b"};
        vecs[2]  = '{1'b1, 1'b0, fc, fb, "stall_1"};
        vecs[3]  = '{1'b1, 1'b0, fc, fb, "stall_2"};
        vecs[4]  = '{1'b0, 1'b0, fc, fc, "stall_release"};
        vecs[5]  = '{1'b0, 1'b0, fb, fb, "reload_b"};
        vecs[6]  = '{1'b0, 1'b1, fd, zero_f, "flush_bubble"};
        vecs[7]  = '{1'b0, 1'b0, fd, fd, "after_flush"};
        vecs[8]  = '{1'b1, 1'b1, fe, zero_f, "flush_over_stall"};
        vecs[9]  = '{1'b0, 1'b0, fe, fe, "after_flush_stall"};
        vecs[10] = '{1'b0, 1'b0, ff, ff, "invalid_passes"};
        for (int i = 0; i < 4; i++) begin
            fields_t t;
            t = mk(1'b1, 4'hE, 2'b00, 7'b0100000, 2'b00, 32'h100 + 32'(i), 32'h0, 32'h0,
                   4'd0, 4'd0, 4'(i + 1));
            vecs[11 + i] = '{1'b0, 1'b0, t, t, $sformatf("b2b_wa3_%0d", i + 1)};
        end
        vecs[15] = '{1'b1, 1'b0, fa, vecs[14].e, "stall_after_b2b"};

        // Reset behaviour with all D inputs at ones
        reset  = 1'b1;
        StallE = 1'b0;
        FlushE = 1'b0;
        din    = '1;
        @(posedge clk);
        #1 check("reset_held", zero_f);
        @(negedge clk);
        reset = 1'b0;
        #1 check("reset_release_no_edge", zero_f);
        @(posedge clk);
        #1 check("first_load_ones", ones_f);
        #2 reset = 1'b1;
        #1 check("async_reset_mid_cycle", zero_f);
        @(posedge clk);
        #1 check("reset_over_edge", zero_f);
        @(negedge clk);
        reset = 1'b0;
        din   = '0;

        // Table-driven main sequence
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            StallE = vecs[i].stall;
            FlushE = vecs[i].flush;
            din    = vecs[i].d;
            @(posedge clk);
            #1 check(vecs[i].name, vecs[i].e);
        end

        // Long stall: output holds for several edges, then pending data loads
        @(negedge clk);
        StallE = 1'b1;
        din    = fd;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1 check($sformatf("long_stall_%0d", k), vecs[14].e);
        end
        @(negedge clk);
        StallE = 1'b0;
        @(posedge clk);
        #1 check("long_stall_release", fd);
        @(negedge clk);
        FlushE = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
